// File: rtl/audio_out_pkg.sv
// Shared audio-subsystem constants, used by the playback (audio_out) and
// capture sides.
//   DATA_W_DEF      default sample width per channel
//   UNDERRUN_ZERO   on underrun, send a frame of zeros
//   UNDERRUN_REPEAT on underrun, resend the last pair that was sent
//   LEFT_LEVEL      LRCLK level that marks the left slot
package audio_out_pkg;

  localparam int   DATA_W_DEF      = 16;
  localparam int   UNDERRUN_ZERO   = 0;
  localparam int   UNDERRUN_REPEAT = 1;
  localparam logic LEFT_LEVEL      = 1'b0;

endpackage

// File: rtl/audio_out_lr_edge.sv
// i2s_lr_edge: finds LRCLK slot boundaries in the BCLK domain. The receiver
// can reuse it.
//   BCLK        bit clock; all logic runs on posedge
//   RST         asynchronous reset, active high
//   LRCLK       left/right clock from the codec
//   left_edge   combinational; high on the posedge that begins a left slot
//   right_edge  combinational; high on the posedge that begins a right slot
// The first posedge after reset only samples LRCLK. The reset value of
// lrclk_prev can therefore never look like a transition.
module i2s_lr_edge
  import audio_out_pkg::*;
(
  input  logic BCLK,
  input  logic RST,
  input  logic LRCLK,
  output logic left_edge,
  output logic right_edge
);

  logic primed;
  logic lrclk_prev;

  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      primed     <= 1'b0;
      lrclk_prev <= 1'b0;
    end else begin
      primed     <= 1'b1;
      lrclk_prev <= LRCLK;
    end
  end

  assign left_edge  = primed && (lrclk_prev != LEFT_LEVEL) && (LRCLK == LEFT_LEVEL);
  assign right_edge = primed && (lrclk_prev == LEFT_LEVEL) && (LRCLK != LEFT_LEVEL);

endmodule

// File: rtl/audio_out.sv
// audio_out: I2S transmitter. The codec is the clock master and supplies
// BCLK and LRCLK.
//   BCLK, RST         bit clock (posedge) and asynchronous active-high reset
//   LRCLK             slot select from the codec (low = left)
//   in_left/in_right  signed stereo pair
//   in_valid/in_ready handshake into a holding buffer that holds one pair
//   DACDAT            registered serial data, sent MSB first, one BCLK
//                     after each LRCLK transition
//   frame_start       pulses for one cycle at each left slot
//   underrun          pulses for one cycle when a frame starts with the
//                     buffer empty
//   underrun_count    counts underruns; stops at all-ones
module audio_out
  import audio_out_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int UNDERRUN_MODE = UNDERRUN_ZERO,
  parameter int CNT_W         = 16
) (
  input  logic                     BCLK,
  input  logic                     RST,
  input  logic                     LRCLK,
  input  logic signed [DATA_W-1:0] in_left,
  input  logic signed [DATA_W-1:0] in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     DACDAT,
  output logic                     frame_start,
  output logic                     underrun,
  output logic [CNT_W-1:0]         underrun_count
);

  localparam int             CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  SENT_ALL = CW'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  logic              left_edge, right_edge;
  logic              take;
  logic              synced;
  pair_t             hold_q;      // holding buffer; full when in_ready is low
  pair_t             last_q;      // last pair taken from the buffer
  pair_t             src;         // pair the next frame will use
  logic [DATA_W-1:0] act_r;       // right word, latched with the left word at frame start
  logic [DATA_W-1:0] shreg;       // bits of the current slot not yet sent
  logic [CW-1:0]     bit_cnt;     // bits already sent in this slot

  i2s_lr_edge u_edge (
    .BCLK       (BCLK),
    .RST        (RST),
    .LRCLK      (LRCLK),
    .left_edge  (left_edge),
    .right_edge (right_edge)
  );

  assign take = in_valid && in_ready;

  always_comb begin
    src = '0;
    if (!in_ready)
      src = hold_q;
    else if (UNDERRUN_MODE == UNDERRUN_REPEAT)
      src = last_q;
  end

  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      in_ready       <= 1'b1;
      hold_q         <= '0;
      last_q         <= '0;
      act_r          <= '0;
      synced         <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      DACDAT         <= 1'b0;
    end else begin
      frame_start <= left_edge;
      underrun    <= left_edge && in_ready;

      // A pair accepted on a left edge waits for the next frame. The
      // frame-start path reads the old buffer state, so there is no bypass.
      if (take)
        hold_q <= {in_left, in_right};
      in_ready <= !(take || (!in_ready && !left_edge));

      if (left_edge) begin
        synced <= 1'b1;
        act_r  <= src.r;
        if (!in_ready)
          last_q <= hold_q;
        else if (~&underrun_count)
          underrun_count <= underrun_count + 1'b1;
      end

      // The MSB goes out on the edge cycle, so the count starts at one bit sent.
      // A late edge drops the unsent LSBs of the word it interrupts.
      if (left_edge) begin
        DACDAT  <= src.l[DATA_W-1];
        shreg   <= {src.l[DATA_W-2:0], 1'b0};
        bit_cnt <= CW'(1);
      end else if (right_edge && synced) begin
        DACDAT  <= act_r[DATA_W-1];
        shreg   <= {act_r[DATA_W-2:0], 1'b0};
        bit_cnt <= CW'(1);
      end else if (synced && bit_cnt < SENT_ALL) begin
        DACDAT  <= shreg[DATA_W-1];
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        DACDAT  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_out.sv
module tb_audio_out;

  localparam int DW = 16;

  logic        BCLK = 1'b0;
  logic        RST = 1'b1;
  logic        LRCLK = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0, in_right = '0;
  logic        rdy0, rdy1, dac0, dac1, fs0, fs1, ur0, ur1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int n_pass = 0, n_tot = 0;

  always #5 BCLK = ~BCLK;

  audio_out #(.DATA_W(16), .UNDERRUN_MODE(0), .CNT_W(16)) u0 (
    .BCLK(BCLK), .RST(RST), .LRCLK(LRCLK), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(rdy0), .DACDAT(dac0), .frame_start(fs0),
    .underrun(ur0), .underrun_count(cnt0));

  audio_out #(.DATA_W(16), .UNDERRUN_MODE(1), .CNT_W(3)) u1 (
    .BCLK(BCLK), .RST(RST), .LRCLK(LRCLK), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(rdy1), .DACDAT(dac1), .frame_start(fs1),
    .underrun(ur1), .underrun_count(cnt1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 is the zero-fill instance and index 1 is the repeat instance with
  // the 3-bit counter. Both see the same stimulus, so they share the buffer
  // and the slot position. Each instance has its own frame pair and counter.
  int          age = 0;          // posedges since reset release (capped)
  bit          lr_last = 1'b0;
  bit          m_synced = 1'b0;
  int          pos = 0;          // bit index within the current slot
  bit          chan = 1'b0;      // 0 left, 1 right
  logic [31:0] q[$];             // holding buffer, at most one pair
  logic [31:0] frame[2] = '{32'h0, 32'h0};
  logic [31:0] last[2]  = '{32'h0, 32'h0};
  int          ucnt[2]  = '{0, 0};
  int          cmax[2]  = '{65535, 7};
  bit          e_fs = 1'b0, e_ur = 1'b0;
  bit          m_le, m_re, m_take;

  initial forever begin
    @(posedge BCLK or posedge RST);
    if (RST) begin
      age = 0; lr_last = 1'b0; m_synced = 1'b0; pos = 0; chan = 1'b0;
      q.delete(); frame = '{32'h0, 32'h0}; last = '{32'h0, 32'h0};
      ucnt = '{0, 0}; e_fs = 1'b0; e_ur = 1'b0;
    end else begin
      m_le   = (age > 0) && lr_last && !LRCLK;
      m_re   = (age > 0) && !lr_last && LRCLK;
      m_take = in_valid && (q.size() == 0);
      e_fs   = m_le;
      e_ur   = m_le && (q.size() == 0);
      if (m_le) begin
        m_synced = 1'b1; chan = 1'b0; pos = 0;
        for (int i = 0; i < 2; i++) begin
          if (q.size() != 0) begin
            frame[i] = q[0]; last[i] = q[0];
          end else begin
            frame[i] = (i == 1) ? last[i] : 32'h0;
            if (ucnt[i] < cmax[i]) ucnt[i]++;
          end
        end
        if (q.size() != 0) void'(q.pop_front());
      end else if (m_re && m_synced) begin
        chan = 1'b1; pos = 0;
      end else if (pos < DW) begin
        pos++;
      end
      if (m_take) q.push_back({in_left, in_right});
      lr_last = LRCLK;
      if (age < 2) age++;
    end
  end

  function automatic logic exp_dac(input int i);
    logic [15:0] w;
    if (!m_synced || pos >= DW) return 1'b0;
    w = chan ? frame[i][15:0] : frame[i][31:16];
    return w[DW-1-pos];
  endfunction

  initial forever begin
    @(posedge BCLK);
    #1;
    chk("dac0", 64'(dac0), 64'(exp_dac(0)));
    chk("dac1", 64'(dac1), 64'(exp_dac(1)));
    chk("ready0", 64'(rdy0), 64'(q.size() == 0));
    chk("ready1", 64'(rdy1), 64'(q.size() == 0));
    chk("fs0", 64'(fs0), 64'(e_fs));
    chk("fs1", 64'(fs1), 64'(e_fs));
    chk("ur0", 64'(ur0), 64'(e_ur));
    chk("ur1", 64'(ur1), 64'(e_ur));
    chk("cnt0", 64'(cnt0), 64'(ucnt[0]));
    chk("cnt1", 64'(cnt1), 64'(ucnt[1]));
  end

  // ---------------- LRCLK generator ----------------
  int slot_len = 32, lr_cnt = 0;
  bit lr_run = 1'b0;

  initial forever begin
    @(negedge BCLK);
    if (lr_run) begin
      if (lr_cnt >= slot_len - 1) begin LRCLK = ~LRCLK; lr_cnt = 0; end
      else lr_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Leaves in_valid high after acceptance so that back-to-back pushes keep it asserted.
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bit ok = 1'b0;
    if (!in_valid) @(negedge BCLK);
    in_valid = 1'b1; in_left = l; in_right = r;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (rdy0) ok = 1'b1;
      @(negedge BCLK);
    end
    if (!ok) begin n_tot++; $display("FAIL push_timeout: pair %h/%h not accepted", l, r); end
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    push(l, r);
    in_valid = 1'b0;
  endtask

  task automatic wait_fs();
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge BCLK); #1;
      if (fs0) ok = 1'b1;
    end
    if (!ok) begin n_tot++; $display("FAIL fs_timeout: no frame_start within 3000 cycles"); end
  endtask

  // Captures n DACDAT bits from both instances, starting at the next frame start.
  task automatic grab(input int n, output logic [63:0] b0, output logic [63:0] b1);
    b0 = '0; b1 = '0;
    wait_fs();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge BCLK); #1; end
      b0 = {b0[62:0], dac0};
      b1 = {b1[62:0], dac1};
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] g0, g1;
  int fs_n;

  initial begin
    // Reset values
    repeat (3) @(posedge BCLK);
    #1;
    chk("rst_dac", 64'(dac0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_fs", 64'(fs0), 64'd0);

    // Priming cycle with LRCLK high, then a fall gives exactly one frame start
    @(negedge BCLK); RST = 1'b0;
    @(posedge BCLK); #1;
    chk("prime_fs", 64'(fs0), 64'd0);
    @(negedge BCLK); LRCLK = 1'b0;
    fs_n = 0;
    for (int k = 0; k < 6; k++) begin @(posedge BCLK); #1; fs_n += int'(fs0); end
    chk("first_fs_pulses", 64'(fs_n), 64'd1);
    chk("first_underrun_cnt", 64'(cnt0), 64'd1);

    // 32-BCLK slots carrying 0x8001 / 0x7FFE
    send(16'h8001, 16'h7FFE);
    slot_len = 32; lr_cnt = 0; lr_run = 1'b1;
    grab(64, g0, g1);
    chk("frame_8001_u0", g0, 64'h8001_0000_7FFE_0000);
    chk("frame_8001_u1", g1, 64'h8001_0000_7FFE_0000);

    // This pair is accepted on the next left edge, so that frame underruns.
    send(16'h1234, 16'hABCD);
    grab(64, g0, g1);
    chk("frame_1234_u0", g0, 64'h1234_0000_ABCD_0000);
    chk("frame_1234_u1", g1, 64'h1234_0000_ABCD_0000);
    chk("nobypass_cnt", 64'(cnt0), 64'd2);
    grab(64, g0, g1);
    chk("underrun_zero", g0, 64'h0);
    chk("underrun_repeat", g1, 64'h1234_0000_ABCD_0000);
    chk("underrun_cnt0", 64'(cnt0), 64'd3);
    chk("underrun_cnt1", 64'(cnt1), 64'd3);

    // Keep in_valid high: one pair is consumed per frame
    push(16'h0101, 16'h0202);
    push(16'h0303, 16'h0404);
    push(16'h0505, 16'h0606);
    push(16'hC3A5, 16'h5A3C);
    in_valid = 1'b0;
    grab(64, g0, g1);
    chk("stream_last_pair", g0, 64'hC3A5_0000_5A3C_0000);

    // Short 12-BCLK slots: only the top 12 bits of each word go out
    slot_len = 12;
    send(16'hABCD, 16'h1357);
    grab(24, g0, g1);
    chk("short_slot_u0", g0, 64'h0000_0000_00AB_C135);
    chk("short_slot_u1", g1, 64'h0000_0000_00AB_C135);

    // Six empty frames; the 3-bit counter stops at 7
    for (int k = 0; k < 6; k++) wait_fs();
    chk("cnt0_after_storm", 64'(cnt0), 64'd11);
    chk("cnt1_saturated", 64'(cnt1), 64'd7);

    // Reset in the middle of a left slot
    repeat (4) @(negedge BCLK);
    RST = 1'b1;
    @(posedge BCLK); #1;
    chk("midrst_dac", 64'(dac0), 64'd0);
    chk("midrst_ready", 64'(rdy0), 64'd1);
    chk("midrst_cnt0", 64'(cnt0), 64'd0);
    chk("midrst_cnt1", 64'(cnt1), 64'd0);
    repeat (2) @(negedge BCLK);
    RST = 1'b0;
    send(16'h8001, 16'h7FFE);
    grab(24, g0, g1);
    chk("post_rst_frame", g0, 64'h0000_0000_0080_07FF);
    chk("post_rst_cnt", 64'(cnt0), 64'd0);

    repeat (4) @(posedge BCLK);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/audio_out.md
Name: audio_out

Overview:
I2S transmitter that drives the codec's serial DAC input. It is clocked by the codec-supplied bit clock and follows the codec-supplied LRCLK (the codec is clock master). Stereo sample pairs arrive from the effects chain over a valid/ready handshake into a one-pair holding buffer, and are serialized MSB-first with the standard I2S one-bit delay. It is the playback-side counterpart of the capture path in the same audio subsystem.

Parameters:
DATA_W, 16, sample width in bits per channel.
UNDERRUN_MODE, 0, frame source on underrun: 0 = transmit zeros, 1 = repeat last transmitted pair.
CNT_W, 16, width of the underrun counter.

Ports:
BCLK  input  1  bit clock from codec; the only clock, all logic on posedge
RST  input  1  asynchronous, active-high reset
LRCLK  input  1  left/right clock from codec; low = left, high = right
in_left  input  DATA_W  signed left sample
in_right  input  DATA_W  signed right sample
in_valid  input  1  pair valid
in_ready  output  1  holding buffer empty, can accept a pair
DACDAT  output  1  serial DAC data, registered
frame_start  output  1  one-cycle pulse at each left-channel start
underrun  output  1  one-cycle pulse when a frame starts with no pending pair
underrun_count  output  CNT_W  saturating count of underruns

Behaviour:
- Reset values:
  - DACDAT=0, in_ready=1, frame_start=0, underrun=0, underrun_count=0.
  - Holding buffer empty; active pair and last pair = 0.
  - synced=0, primed=0, bit counter=0.
- Edge detection:
  - lrclk_prev registers LRCLK each cycle.
  - The first cycle after reset release only loads lrclk_prev and sets primed; no edge is detected on that cycle.
  - Left edge = primed and lrclk_prev=1 and LRCLK=0. Right edge = primed and lrclk_prev=0 and LRCLK=1.
- Handshake:
  - A transfer happens when in_valid and in_ready are both high on a posedge; the pair is written to the holding buffer.
  - in_ready equals not-full, registered.
  - No bypass: a pair accepted on the same edge as a left edge is not used for that frame.
- Left edge:
  - synced is set. frame_start pulses the next cycle.
  - If the buffer is full, the pair moves to active and to last, and the buffer clears. in_ready is high from the next cycle.
  - If the buffer is empty, this is an underrun. The active pair becomes zeros (UNDERRUN_MODE=0) or the last pair (UNDERRUN_MODE=1). underrun pulses, and underrun_count increments, saturating at all-ones.
  - Left and right for a frame always come from the same pair; right is never reloaded at the right edge.
- Serialization:
  - On an edge detected at posedge n, the bit counter resets and DACDAT<=MSB of the channel word at posedge n. Following posedges shift the next bits out, MSB first.
  - After DATA_W bits, DACDAT=0 until the next edge; the bit counter saturates at DATA_W.
  - Short slot: if an edge arrives before DATA_W bits are sent, the remaining LSBs are dropped and the new word starts immediately.
- Before synced, DACDAT=0 and right edges are ignored. Pairs are still accepted into the buffer.
- Reset mid-frame returns everything to reset values. Transmission resumes only at the first left edge after the priming cycle.

Decomposition:
- Shared audio package holds:
  - DATA_W default and the underrun-mode constants (zero, repeat).
  - The LRCLK polarity constant (LEFT_LEVEL=0), also used by the capture side.
- One natural sub-module: i2s_lr_edge, covering the primed flag, lrclk_prev and the left/right edge pulses. It is reusable by the receiver.
- The serializer shift register and counter stay inline.

Test Plan:
- Reset release with LRCLK held high, then LRCLK falls -> no edge on the priming cycle; one left edge at the fall; frame_start pulses once.
- Load pair L=0x8001, R=0x7FFE, 32-BCLK slots -> DACDAT carries 1000000000000001 then 16 zeros in the left slot, 0111111111111110 then 16 zeros in the right slot.
- No pair loaded, UNDERRUN_MODE=0 -> zeros transmitted, underrun pulses, underrun_count=1. Repeat with mode 1 after pair 0x1234/0xABCD -> same pair re-sent, count increments.
- Hold in_valid with frames running -> in_ready drops after acceptance and returns the cycle after the left edge. Exactly one pair consumed per frame; none lost or duplicated.
- 12-BCLK slots with DATA_W=16 -> only the 12 MSBs are sent per channel; the next word starts MSB at the edge.
- Assert RST mid-left-slot -> DACDAT=0, in_ready=1, count=0; first output is at the next left edge after priming.
